// File: rtl/gsim_pkg.sv
// Shared definitions for the Gauss-Seidel I/O controller: sizes, FSM
// encoding and the A/b bus packing helpers.
package gsim_pkg;

    localparam int N         = 16;   // matrix dimension
    localparam int DW        = 16;   // A/b element width
    localparam int XW        = 32;   // solution element width
    localparam int A_WORDS   = 256;  // N*N matrix words
    localparam int TOT_WORDS = 272;  // matrix words followed by N vector words
    localparam int CW        = 9;    // word counter width

    localparam logic [CW-1:0] LAST_WORD = CW'(TOT_WORDS - 1);

    typedef enum logic [1:0] {
        S_LOAD    = 2'd0,
        S_RUN     = 2'd1,
        S_DRAIN   = 2'd2,
        S_RELEASE = 2'd3
    } gsim_state_e;

    // Bit offset of A(row, col) on the core bus: the core stores A column-major,
    // so the column selects a 256-bit group and the row a 16-bit lane inside it.
    function automatic logic [11:0] a_pack_offset(input logic [3:0] row,
                                                  input logic [3:0] col);
        return {col, row, 4'b0000};
    endfunction

    // Bit offset of b(idx) on the core bus.
    function automatic logic [7:0] b_pack_offset(input logic [3:0] idx);
        return {idx, 4'b0000};
    endfunction

endpackage

// File: rtl/gsim_out_serializer.sv
// Captures the solver's 16-word solution vector on a strobe and streams it
// out one word per valid/ready handshake, holding data steady across stalls.
module gsim_out_serializer
    import gsim_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              capture_i,
    input  logic [N*XW-1:0]   x_i,
    input  logic              out_ready_i,
    output logic              out_valid_o,
    output logic [XW-1:0]     out_data_o,
    output logic              last_xfer_o
);

    logic [N-1:0][XW-1:0] buf_q;
    logic [3:0]           idx_q;
    logic                 valid_q;
    logic [XW-1:0]        data_q;
    logic                 xfer;

    assign xfer        = valid_q && out_ready_i;
    assign last_xfer_o = xfer && (idx_q == 4'(N - 1));

    // Snapshot the solution, then advance one word per accepted transfer.
    // NOTE: the solution buffer is reset on purpose so that a reset mid-drain
    // leaves no stale solution visible; most storage arrays would skip reset.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            buf_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (capture_i) begin
            buf_q   <= x_i;
            data_q  <= x_i[XW-1:0];
            idx_q   <= '0;
            valid_q <= 1'b1;
        end else if (xfer) begin
            if (idx_q == 4'(N - 1)) begin
                valid_q <= 1'b0;
            end else begin
                idx_q  <= idx_q + 4'd1;
                data_q <= buf_q[idx_q + 4'd1];
            end
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

endmodule

// File: rtl/gsim_io_ctrl.sv
// Front/back-end controller for the Gauss-Seidel core: loads A and b from a
// serial word stream, enables the core until done, then drains the solution.
module gsim_io_ctrl
    import gsim_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_in_valid,
    input  logic [DW-1:0]        i_in_data,
    output logic                 o_in_ready,
    output logic                 o_module_en,
    input  logic                 i_done,
    output logic [N*N*DW-1:0]    o_a,
    output logic [N*DW-1:0]      o_b,
    input  logic [N*XW-1:0]      i_x,
    output logic                 o_out_valid,
    output logic [XW-1:0]        o_out_data,
    input  logic                 i_out_ready,
    output logic                 o_busy
);

    gsim_state_e         state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                in_ready_q, in_ready_d;
    logic                module_en_q, module_en_d;
    logic                busy_q;
    logic [N*N*DW-1:0]   a_q;
    logic [N*DW-1:0]     b_q;
    logic                accept;
    logic                capture;
    logic                last_xfer;

    // Next-state and control decode for the load/run/drain/release sequence.
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; a missing default would infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        module_en_d = module_en_q;
        accept      = 1'b0;
        capture     = 1'b0;
        case (state_q)
            S_LOAD: begin
                accept = i_in_valid && in_ready_q;
                if (accept) begin
                    if (cnt_q == LAST_WORD) begin
                        cnt_d       = '0;
                        in_ready_d  = 1'b0;
                        module_en_d = 1'b1;
                        state_d     = S_RUN;
                    end else begin
                        cnt_d = cnt_q + 9'd1;
                    end
                end
            end
            S_RUN: begin
                if (i_done) begin
                    capture = 1'b1;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (last_xfer) begin
                    module_en_d = 1'b0;
                    state_d     = S_RELEASE;
                end
            end
            S_RELEASE: begin
                // The core holds done until enable drops; wait for it to clear.
                if (!i_done) begin
                    in_ready_d = 1'b1;
                    state_d    = S_LOAD;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    // State, counter and registered control outputs.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= S_LOAD;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            module_en_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            module_en_q <= module_en_d;
            busy_q      <= (state_d != S_LOAD);
        end
    end

    // Place each accepted word at its column-major slot on the A or b bus.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            a_q <= '0;
            b_q <= '0;
        end else if (accept) begin
            if (!cnt_q[8]) begin
                a_q[a_pack_offset(cnt_q[7:4], cnt_q[3:0]) +: DW] <= i_in_data;
            end else begin
                b_q[b_pack_offset(cnt_q[3:0]) +: DW] <= i_in_data;
            end
        end
    end

    gsim_out_serializer u_out_serializer (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .capture_i   (capture),
        .x_i         (i_x),
        .out_ready_i (i_out_ready),
        .out_valid_o (o_out_valid),
        .out_data_o  (o_out_data),
        .last_xfer_o (last_xfer)
    );

    assign o_in_ready  = in_ready_q;
    assign o_module_en = module_en_q;
    assign o_busy      = busy_q;
    assign o_a         = a_q;
    assign o_b         = b_q;

endmodule

// File: tb/tb_gsim_io_ctrl.sv
// Self-checking bench for gsim_io_ctrl: randomized loads checked against a
// row/column matrix model, solution drain checked through a scoreboard queue.
module tb_gsim_io_ctrl;
    import gsim_pkg::*;

    logic           i_clk = 1'b0;
    logic           i_reset;
    logic           i_in_valid;
    logic [15:0]    i_in_data;
    logic           o_in_ready;
    logic           o_module_en;
    logic           i_done;
    logic [4095:0]  o_a;
    logic [255:0]   o_b;
    logic [511:0]   i_x;
    logic           o_out_valid;
    logic [31:0]    o_out_data;
    logic           i_out_ready;
    logic           o_busy;

    int checks = 0;
    int errors = 0;

    logic [15:0] words [272];   // stream in order: A row-major, then b
    logic [31:0] exp_q [$];     // expected solution words, in output order
    int          xfer_cnt = 0;
    int          rdy_mode = 0;  // 0: always ready, 1: alternate, 2: random
    bit          stall_pending = 0;
    logic [31:0] stall_data;

    gsim_io_ctrl dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_in_valid  (i_in_valid),
        .i_in_data   (i_in_data),
        .o_in_ready  (o_in_ready),
        .o_module_en (o_module_en),
        .i_done      (i_done),
        .o_a         (o_a),
        .o_b         (o_b),
        .i_x         (i_x),
        .o_out_valid (o_out_valid),
        .o_out_data  (o_out_data),
        .i_out_ready (i_out_ready),
        .o_busy      (o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Downstream sink: ready pattern changes just after each rising edge.
    initial begin
        i_out_ready = 1'b0;
        forever begin
            @(posedge i_clk);
            #1;
            case (rdy_mode)
                0:       i_out_ready = 1'b1;
                1:       i_out_ready = ~i_out_ready;
                default: i_out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pops the scoreboard on every output handshake, checks stalls hold.
    initial begin
        forever begin
            @(negedge i_clk);
            if (stall_pending)
                check("stall_hold", {o_out_valid, o_out_data}, {1'b1, stall_data});
            stall_pending = 0;
            if (!i_reset && o_out_valid) begin
                if (i_out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_out", o_out_data, 64'hDEAD_0000_0000);
                    end else begin
                        check($sformatf("out_word%0d", xfer_cnt), o_out_data, exp_q.pop_front());
                    end
                    xfer_cnt++;
                end else begin
                    stall_pending = 1;
                    stall_data    = o_out_data;
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    // Compare the whole A/b bus against the matrix model built from words[].
    task automatic check_packing();
        for (int k = 0; k < TOT_WORDS; k++) begin
            int r, c;
            r = k / 16;
            c = k % 16;
            if (k < A_WORDS)
                check($sformatf("a_r%0d_c%0d", r, c), o_a[c*256 + r*16 +: 16], words[k]);
            else
                check($sformatf("b_%0d", k - A_WORDS), o_b[(k - A_WORDS)*16 +: 16], words[k]);
        end
    endtask

    // Stream words[0..stop_at-1]; vmode 0: valid always, 1: alternate plus a
    // 20-cycle gap at word 100, 2: random valid.
    task automatic load_words(input int vmode, input int stop_at);
        int k = 0, cyc = 0, gap = 0;
        bit early_en = 0;
        bit v;
        while (k < stop_at && cyc < 3000) begin
            @(negedge i_clk);
            cyc++;
            if (o_module_en) early_en = 1;
            case (vmode)
                0: v = 1'b1;
                1: begin
                    if (k == 100 && gap < 20) begin
                        v = 1'b0;
                        gap++;
                    end else begin
                        v = (cyc % 2 == 0);
                    end
                end
                default: v = 1'($urandom_range(0, 1));
            endcase
            i_in_valid = v;
            i_in_data  = v ? words[k] : 16'($urandom);
            if (v && o_in_ready) k++;
        end
        check("load_count", k, stop_at);
        if (stop_at == TOT_WORDS) begin
            check("en_early", early_en, 0);
            @(negedge i_clk);
            i_in_valid = 1'b0;
            check("en_rise", o_module_en, 1);
            check("ready_drop", o_in_ready, 0);
            check("busy_run", o_busy, 1);
        end
    endtask

    // Core stub: done 300 cycles after enable, then drain and release.
    task automatic run_problem(input int rmode, input bit rand_x);
        logic [31:0] xv [16];
        bit bad_run = 0, bad_drain = 0, bad_rel = 0;
        int cyc = 0;
        for (int i = 0; i < 16; i++) begin
            xv[i] = rand_x ? $urandom : 32'(i) * 32'h0001_0000;
            i_x[i*32 +: 32] = xv[i];
        end
        rdy_mode = rmode;
        xfer_cnt = 0;
        // Input words offered while running must be refused and not stored.
        repeat (300) begin
            @(negedge i_clk);
            i_in_valid = 1'b1;
            i_in_data  = 16'($urandom);
            if (o_in_ready || o_out_valid || !o_module_en || !o_busy) bad_run = 1;
        end
        check("run_quiet", bad_run, 0);
        i_in_valid = 1'b0;
        for (int i = 0; i < 16; i++) exp_q.push_back(xv[i]);
        i_done = 1'b1;
        @(negedge i_clk);
        i_x = ~i_x;  // the captured copy must be used from here on
        while (xfer_cnt < 16 && cyc < 400) begin
            @(negedge i_clk);
            #1;
            cyc++;
            if (!o_module_en) bad_drain = 1;
        end
        check("drain_done", xfer_cnt, 16);
        check("drain_en_held", bad_drain, 0);
        @(negedge i_clk);
        check("en_fall", o_module_en, 0);
        check("valid_fall", o_out_valid, 0);
        check("ready_held_low", o_in_ready, 0);
        check("busy_release", o_busy, 1);
        repeat (4) begin
            @(negedge i_clk);
            if (o_in_ready || o_module_en) bad_rel = 1;
        end
        check("release_wait", bad_rel, 0);
        i_done = 1'b0;
        @(negedge i_clk);
        check("ready_back", o_in_ready, 1);
        check("busy_idle", o_busy, 0);
        repeat (3) @(negedge i_clk);
        check("xfer_total", xfer_cnt, 16);
        check("scoreboard_empty", exp_q.size(), 0);
        check_packing();
    endtask

    initial begin
        i_reset    = 1'b1;
        i_in_valid = 1'b0;
        i_in_data  = '0;
        i_done     = 1'b0;
        i_x        = '0;
        repeat (3) @(negedge i_clk);
        check("rst_ready", o_in_ready, 1);
        check("rst_en", o_module_en, 0);
        check("rst_valid", o_out_valid, 0);
        check("rst_data", o_out_data, 0);
        check("rst_a_zero", o_a == '0, 1);
        check("rst_b_zero", o_b == '0, 1);
        check("rst_busy", o_busy, 0);
        i_reset = 1'b0;

        // done pulsed while loading is ignored
        repeat (3) begin
            @(negedge i_clk);
            i_done = 1'b1;
        end
        @(negedge i_clk);
        i_done = 1'b0;
        check("done_in_load_en", o_module_en, 0);
        check("done_in_load_valid", o_out_valid, 0);
        check("done_in_load_busy", o_busy, 0);
        check("done_in_load_ready", o_in_ready, 1);

        // k+1 stream with valid gaps, then a drain with alternating ready
        for (int k = 0; k < TOT_WORDS; k++) words[k] = 16'(k + 1);
        load_words(1, TOT_WORDS);
        check_packing();
        run_problem(1, 0);

        // random words, random valid, random solution and random ready
        for (int k = 0; k < TOT_WORDS; k++) words[k] = 16'($urandom);
        load_words(2, TOT_WORDS);
        check_packing();
        run_problem(2, 1);

        // reset in the middle of a load
        for (int k = 0; k < TOT_WORDS; k++) words[k] = 16'($urandom);
        load_words(0, 100);
        @(negedge i_clk);
        i_in_valid = 1'b0;
        i_reset    = 1'b1;
        #1;
        check("midrst_a_zero", o_a == '0, 1);
        check("midrst_b_zero", o_b == '0, 1);
        check("midrst_en", o_module_en, 0);
        check("midrst_valid", o_out_valid, 0);
        check("midrst_busy", o_busy, 0);
        repeat (2) @(negedge i_clk);
        i_reset = 1'b0;
        @(negedge i_clk);
        check("midrst_ready", o_in_ready, 1);

        // full continuous k+1 load from k=0 with the named spot values
        for (int k = 0; k < TOT_WORDS; k++) words[k] = 16'(k + 1);
        load_words(0, TOT_WORDS);
        check("spot_r0c0", o_a[15:0], 16'h0001);
        check("spot_r0c1", o_a[271:256], 16'h0002);
        check("spot_r1c0", o_a[31:16], 16'h0011);
        check("spot_r15c15", o_a[4095:4080], 16'h0100);
        check("spot_b0", o_b[15:0], 16'h0101);
        check_packing();
        run_problem(0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
